// File: rtl/fabric_ccff_shadow_mem.sv
// fabric_ccff_shadow_mem
//   Configuration-memory segment for fabric routing muxes. Bits shift
//   through a staging chain of NUM_MUX*SRAM_PER_MUX data bits plus one
//   even-parity bit. Staged data reaches the shadow registers that drive
//   the mux sram only after a validated commit.
//
// Ports:
//   prog_clk     configuration clock (only clock)
//   pReset       synchronous active-high reset
//   ccff_head    serial config bit in
//   ccff_en      shift enable, one bit per cycle
//   commit_req   single-cycle request to commit staged data
//   ccff_tail    serial config bit out (registered, last chain stage)
//   mem_out      shadow sram bits, mux j uses [j*SRAM_PER_MUX +: SRAM_PER_MUX]
//   mem_outb     bitwise inverse of mem_out
//   commit_done  one-cycle pulse after a successful commit
//   cfg_err      sticky error flag, cleared only by pReset
//   locked       set by a successful commit when LOCK_AFTER_COMMIT=1
module fabric_ccff_shadow_mem #(
  parameter int NUM_MUX           = 4,
  parameter int SRAM_PER_MUX      = 2,
  parameter int LOCK_AFTER_COMMIT = 1
) (
  input  logic                            prog_clk,
  input  logic                            pReset,
  input  logic                            ccff_head,
  input  logic                            ccff_en,
  input  logic                            commit_req,
  output logic                            ccff_tail,
  output logic [NUM_MUX*SRAM_PER_MUX-1:0] mem_out,
  output logic [NUM_MUX*SRAM_PER_MUX-1:0] mem_outb,
  output logic                            commit_done,
  output logic                            cfg_err,
  output logic                            locked
);

  localparam int DATA_W = NUM_MUX * SRAM_PER_MUX;
  localparam int TOTAL  = DATA_W + 1;
  localparam int CNT_W  = $clog2(TOTAL + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t state, next_state;

  logic [TOTAL-1:0]  st;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] field;
  logic [DATA_W-1:0] snap;
  logic [DATA_W-1:0] mem_q;
  logic              chk_ok;
  logic              err_q;
  logic              locked_q;
  logic              req_take;
  logic              pass;

  // First bit shifted ends up in st[TOTAL-1] and maps to field[0].
  always_comb begin
    field = '0;
    for (int unsigned j = 0; j < DATA_W; j++) begin
      field[j] = st[TOTAL-1-j];
    end
  end

  // Requests are only taken from IDLE/LOAD; everything about the frame
  // is judged on the cycle the request is sampled, lock on the CHECK cycle.
  assign req_take = commit_req && (state == IDLE || state == LOAD);
  assign pass     = chk_ok && !locked_q;

  // State register
  always_ff @(posedge prog_clk) begin
    if (pReset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (commit_req) next_state = CHECK;
               else if (ccff_en) next_state = LOAD;
      LOAD:    if (commit_req) next_state = CHECK;
      CHECK:   next_state = pass ? COMMIT : (ccff_en ? LOAD : IDLE);
      COMMIT:  next_state = (ccff_en || cnt != '0) ? LOAD : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    commit_done = (state == COMMIT);
  end

  // Datapath: chain, counter, snapshot, shadow and sticky flags
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      st       <= '0;
      cnt      <= '0;
      snap     <= '0;
      chk_ok   <= 1'b0;
      mem_q    <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      if (ccff_en) st <= {st[TOTAL-2:0], ccff_head};

      // Counter restarts on CHECK exit; a shift in that same cycle counts as 1.
      if (state == CHECK) begin
        cnt <= ccff_en ? CNT_W'(1) : '0;
      end else if (ccff_en && cnt != CNT_W'(TOTAL + 1)) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (req_take) begin
        snap   <= field;
        chk_ok <= (cnt == CNT_W'(TOTAL)) && !ccff_en && !(^st);
      end

      if (state == CHECK) begin
        if (pass) begin
          mem_q    <= snap;
          locked_q <= (LOCK_AFTER_COMMIT != 0);
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign ccff_tail = st[TOTAL-1];
  assign mem_out   = mem_q;
  assign mem_outb  = ~mem_q;
  assign cfg_err   = err_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_fabric_ccff_shadow_mem.sv
module tb_fabric_ccff_shadow_mem;

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic       ccff_head;
  logic       ccff_en;
  logic       commit_req;
  logic       ccff_tail;
  logic [7:0] mem_out;
  logic [7:0] mem_outb;
  logic       commit_done;
  logic       cfg_err;
  logic       locked;

  int checks = 0;
  int errors = 0;

  fabric_ccff_shadow_mem #(
    .NUM_MUX(4),
    .SRAM_PER_MUX(2),
    .LOCK_AFTER_COMMIT(1)
  ) dut (
    .prog_clk(prog_clk),
    .pReset(pReset),
    .ccff_head(ccff_head),
    .ccff_en(ccff_en),
    .commit_req(commit_req),
    .ccff_tail(ccff_tail),
    .mem_out(mem_out),
    .mem_outb(mem_outb),
    .commit_done(commit_done),
    .cfg_err(cfg_err),
    .locked(locked)
  );

  always #5 prog_clk = ~prog_clk;

  // Stimulus helpers: inputs change on the falling edge only.
  task automatic do_reset();
    @(negedge prog_clk);
    pReset = 1'b1; ccff_en = 1'b0; commit_req = 1'b0; ccff_head = 1'b0;
    @(negedge prog_clk);
    pReset = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    @(negedge prog_clk);
    ccff_head = b; ccff_en = 1'b1; commit_req = 1'b0;
  endtask

  // bits[0] is shifted first; bits[8] is the parity bit.
  task automatic shift_frame(input logic [8:0] bits);
    for (int i = 0; i < 9; i++) shift_bit(bits[i]);
    @(negedge prog_clk);
    ccff_en = 1'b0;
  endtask

  // Pulses commit_req; returns at the negedge where commit_done would be high.
  task automatic pulse_commit(output logic done_early);
    commit_req = 1'b1; ccff_en = 1'b0;
    @(negedge prog_clk);
    commit_req = 1'b0;
    done_early = commit_done;
    @(negedge prog_clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (mem_out !== 8'h00 || mem_outb !== 8'hFF || ccff_tail !== 1'b0 ||
        commit_done !== 1'b0 || cfg_err !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset: mem_out=%h mem_outb=%h tail=%b done=%b err=%b lock=%b",
               mem_out, mem_outb, ccff_tail, commit_done, cfg_err, locked);
    end
  endtask

  task automatic test_commit_ok();
    logic early;
    do_reset();
    shift_frame(9'b0_0100_1101);   // 1,0,1,1,0,0,1,0 then parity 0
    checks++;
    if (ccff_tail !== 1'b1) begin
      errors++; $display("FAIL ok_tail: got %b want 1", ccff_tail);
    end
    pulse_commit(early);
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("FAIL ok_latency: commit_done early=%b want 0", early);
    end
    checks++;
    if (commit_done !== 1'b1 || mem_out !== 8'h4D || mem_outb !== 8'hB2) begin
      errors++;
      $display("FAIL ok_commit: done=%b mem_out=%h mem_outb=%h want 1 4d b2",
               commit_done, mem_out, mem_outb);
    end
    @(negedge prog_clk);
    checks++;
    if (commit_done !== 1'b0 || locked !== 1'b1 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL ok_after: done=%b lock=%b err=%b want 0 1 0",
               commit_done, locked, cfg_err);
    end
  endtask

  task automatic test_bad_parity();
    logic early;
    do_reset();
    shift_frame(9'b1_0100_1101);
    pulse_commit(early);
    @(negedge prog_clk);
    checks++;
    if (cfg_err !== 1'b1 || commit_done !== 1'b0 || mem_out !== 8'h00 || locked !== 1'b0) begin
      errors++;
      $display("FAIL parity: err=%b done=%b mem_out=%h lock=%b want 1 0 00 0",
               cfg_err, commit_done, mem_out, locked);
    end
  endtask

  task automatic test_overshift();
    logic early;
    do_reset();
    shift_bit(1'b1);              // extra leading bit
    for (int i = 0; i < 8; i++) shift_bit(1'b0);
    @(negedge prog_clk);          // 9th shift has landed
    ccff_en = 1'b0;
    checks++;
    if (ccff_tail !== 1'b1) begin
      errors++; $display("FAIL over_tail: got %b want 1", ccff_tail);
    end
    shift_bit(1'b0);              // 10th shift
    @(negedge prog_clk);
    ccff_en = 1'b0;
    pulse_commit(early);
    @(negedge prog_clk);
    checks++;
    if (cfg_err !== 1'b1 || mem_out !== 8'h00 || locked !== 1'b0) begin
      errors++;
      $display("FAIL overshift: err=%b mem_out=%h lock=%b want 1 00 0",
               cfg_err, mem_out, locked);
    end
  endtask

  task automatic test_locked();
    logic early;
    do_reset();
    shift_frame(9'b0_0100_1101);
    pulse_commit(early);
    @(negedge prog_clk);
    shift_frame(9'b1_1111_1110); // 0,1,1,1,1,1,1,1 parity 1: valid frame
    checks++;
    if (ccff_tail !== 1'b0) begin
      errors++; $display("FAIL lock_tail: got %b want 0", ccff_tail);
    end
    pulse_commit(early);
    checks++;
    if (commit_done !== 1'b0) begin
      errors++; $display("FAIL lock_done: got %b want 0", commit_done);
    end
    @(negedge prog_clk);
    checks++;
    if (cfg_err !== 1'b1 || mem_out !== 8'h4D || locked !== 1'b1) begin
      errors++;
      $display("FAIL locked: err=%b mem_out=%h lock=%b want 1 4d 1",
               cfg_err, mem_out, locked);
    end
  endtask

  task automatic test_en_with_commit();
    do_reset();
    for (int i = 0; i < 8; i++) shift_bit(i[0]);   // 0,1,0,1,0,1,0,1
    @(negedge prog_clk);
    ccff_head = 1'b0; ccff_en = 1'b1; commit_req = 1'b1;  // 9th shift + request
    @(negedge prog_clk);
    ccff_en = 1'b0; commit_req = 1'b0;
    @(negedge prog_clk);
    @(negedge prog_clk);
    checks++;
    if (cfg_err !== 1'b1 || mem_out !== 8'h00 || commit_done !== 1'b0) begin
      errors++;
      $display("FAIL en_commit: err=%b mem_out=%h done=%b want 1 00 0",
               cfg_err, mem_out, commit_done);
    end
  endtask

  task automatic test_idle_commit();
    logic early;
    do_reset();
    pulse_commit(early);
    @(negedge prog_clk);
    checks++;
    if (cfg_err !== 1'b1 || commit_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_commit: err=%b done=%b want 1 0", cfg_err, commit_done);
    end
  endtask

  task automatic test_reset_mid();
    logic early;
    do_reset();
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    @(negedge prog_clk);
    ccff_en = 1'b0; pReset = 1'b1;
    @(negedge prog_clk);
    pReset = 1'b0;
    checks++;
    if (ccff_tail !== 1'b0 || mem_out !== 8'h00 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_load: tail=%b mem_out=%h err=%b want 0 00 0",
               ccff_tail, mem_out, cfg_err);
    end
    shift_frame(9'b1_1000_0011);  // 1,1,0,0,0,0,0,1 parity 1
    pulse_commit(early);
    checks++;
    if (commit_done !== 1'b1 || mem_out !== 8'h83 || mem_outb !== 8'h7C) begin
      errors++;
      $display("FAIL rst_commit: done=%b mem_out=%h mem_outb=%h want 1 83 7c",
               commit_done, mem_out, mem_outb);
    end
    @(negedge prog_clk);
    checks++;
    if (cfg_err !== 1'b0 || locked !== 1'b1) begin
      errors++; $display("FAIL rst_flags: err=%b lock=%b want 0 1", cfg_err, locked);
    end
    // Reset landing on the CHECK cycle must suppress the commit.
    do_reset();
    shift_frame(9'b0_0100_1101);
    commit_req = 1'b1;
    @(negedge prog_clk);
    commit_req = 1'b0; pReset = 1'b1;
    @(negedge prog_clk);
    pReset = 1'b0;
    @(negedge prog_clk);
    checks++;
    if (mem_out !== 8'h00 || commit_done !== 1'b0 || locked !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_check: mem_out=%h done=%b lock=%b err=%b want 00 0 0 0",
               mem_out, commit_done, locked, cfg_err);
    end
  endtask

  initial begin
    pReset = 1'b1; ccff_head = 1'b0; ccff_en = 1'b0; commit_req = 1'b0;
    test_reset();
    test_commit_ok();
    test_bad_parity();
    test_overshift();
    test_locked();
    test_en_with_commit();
    test_idle_commit();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fabric_ccff_shadow_mem.md
Name: fabric_ccff_shadow_mem

Overview:
- Parametrised configuration-memory segment for fabric-level routing muxes.
- Replaces per-mux chained 2-bit ccff memories with one chain segment sized NUM_MUX x SRAM_PER_MUX, plus a trailing even-parity bit.
- Bits shift through a staging chain. They are committed to shadow registers driving mux sram only on an explicit, validated commit, so a partially loaded or corrupted bitstream never reaches the fabric muxes.
- Sits in the ccff chain between the frac_logic memory tail and the next tile.

Parameters:
NUM_MUX, 4, number of routing muxes served
SRAM_PER_MUX, 2, sram bits per mux
LOCK_AFTER_COMMIT, 1, 1 = further commits rejected after first successful commit until pReset
(derived) DATA_W = NUM_MUX*SRAM_PER_MUX; TOTAL = DATA_W+1; CNT_W = clog2(TOTAL+2)

Ports:
prog_clk  input  1  configuration clock, only clock of the block
pReset  input  1  synchronous, active-high reset
ccff_head  input  1  serial config bit in
ccff_en  input  1  shift enable, one bit per cycle
commit_req  input  1  single-cycle request to transfer staged data to shadow
ccff_tail  output  1  serial config bit out to next segment
mem_out  output  DATA_W  shadow sram bits, mux j uses [j*SRAM_PER_MUX +: SRAM_PER_MUX]
mem_outb  output  DATA_W  bitwise inverse of mem_out
commit_done  output  1  one-cycle pulse on successful commit
cfg_err  output  1  sticky error flag
locked  output  1  set after successful commit when LOCK_AFTER_COMMIT=1

Behaviour:
- Clocking and reset:
  - Single clock prog_clk; reset is synchronous and active-high (pReset sampled on the prog_clk rising edge).
  - On reset: staging chain=0, bit counter=0, mem_out=0, mem_outb=all 1, commit_done=0, cfg_err=0, locked=0, ccff_tail=0.
- Staging chain st[0:TOTAL-1]:
  - ccff_en=1: st[0]<=ccff_head, st[i]<=st[i-1].
  - ccff_tail = st[TOTAL-1], a register output with no combinational path from ccff_head.
  - The first bit shifted in reaches ccff_tail after TOTAL shifts.
- Bit counter:
  - Increments per shift and saturates at TOTAL+1, which marks over-shift.
  - Shifting is never blocked by lock or error, so downstream segments stay programmable.
- Field mapping after exactly TOTAL shifts:
  - mem_out[j] = st[TOTAL-1-j] for j=0..DATA_W-1, so the first bit shifted lands in mem_out[0].
  - st[0] is the parity bit.
  - Valid frame = XOR of all TOTAL bits equals 0 (even parity).
- State machine:
  - IDLE: counter==0. ccff_en -> LOAD.
  - LOAD: shifting. commit_req -> CHECK.
  - CHECK: evaluates in one cycle. Pass -> COMMIT. Fail -> IDLE with cfg_err<=1, counter cleared, staged bits left in place.
  - COMMIT: mem_out<=data field, commit_done=1 for this cycle, counter<=0, locked<=LOCK_AFTER_COMMIT, -> IDLE.
  - Latency: commit_req sampled at cycle n; mem_out and commit_done update at the end of cycle n+1.
- Commit pass requires all of:
  - counter==TOTAL;
  - parity ok;
  - locked==0;
  - ccff_en was 0 in the cycle commit_req was sampled.
- Boundary cases:
  - commit_req in IDLE (nothing shifted): rejected, cfg_err<=1.
  - commit_req while in CHECK/COMMIT: ignored.
  - ccff_en during CHECK/COMMIT: shift still occurs. The counter restarts at 1 after COMMIT or a fail, and data captured for commit is the value sampled on entry to CHECK.
  - cfg_err clears only on pReset.
  - locked clears only on pReset; mem_out holds the committed value indefinitely.
  - pReset mid-LOAD or mid-CHECK: everything returns to reset values next edge, and no partial commit is visible.

Test Plan:
- NUM_MUX=4, SRAM_PER_MUX=2 (TOTAL=9): shift 1,0,1,1,0,0,1,0 then parity 0, pulse commit_req -> one cycle later mem_out[0:7]=1,0,1,1,0,0,1,0, mem_outb[0:7]=0,1,0,0,1,1,0,1, commit_done one cycle, locked=1, cfg_err=0.
- Same data with parity bit 1 -> cfg_err=1, commit_done stays 0, mem_out stays all 0.
- 10 shifts (extra bit prepended) then commit_req -> rejected, cfg_err=1. ccff_tail equals the first bit shifted after the 9th shift.
- After a successful commit, shift a new valid 9-bit frame and commit -> rejected (locked), cfg_err=1, mem_out keeps the first value. ccff_tail still forwards the stream.
- commit_req asserted with ccff_en=1 in the same cycle at count 8->9 -> rejected, cfg_err=1.
- pReset asserted for one cycle after 5 shifts, then a full valid frame and commit -> accepted. Prior partial bits have no effect, mem_out matches the new frame, cfg_err=0.
